fc_argmax: RTL and testbench

//  Classifier output stage downstream of the second FC layer. Once fc_2 has written the

---
 rtl/fc_argmax_pkg.sv | 23 ++
 rtl/fc_argmax_if.sv | 53 +++++
 rtl/fc_argmax_top2_tracker.sv | 63 ++++++
 rtl/fc_argmax.sv | 151 +++++++++++++++
 tb/tb_fc_argmax.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_argmax_pkg.sv
// Shared definitions for the classifier output stage.
//   FM_LANE_W     : width of one lane in the fm_bram_1 read word
//   FM_WORD_LANES : lanes per fm_bram_1 read word
//   NUM_CLASS_DEF : default number of class scores
//   state_e       : fc_argmax FSM encoding
package fc_argmax_pkg;

  localparam int unsigned FM_LANE_W     = 16;
  localparam int unsigned FM_WORD_LANES = 56;
  localparam int unsigned FM_WORD_W     = FM_LANE_W * FM_WORD_LANES;
  localparam int unsigned FM_ADDR_W     = 7;
  localparam int unsigned NUM_CLASS_DEF = 10;
  localparam int unsigned CLASS_ID_W    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/fc_argmax_if.sv
// Handshake/result bundle between fc_argmax and its host/BRAM environment.
//   fc_out_en          host -> dut  level enable, rising edge starts a run
//   fm_bram_1_enb      dut -> bram  one-cycle read enable
//   fm_bram_1_addrb    dut -> bram  read address
//   fm_bram_1_doutb    bram -> dut  packed score word
//   fm_bram_1_rdb_vld  bram -> dut  read data valid strobe
//   class_id .. fc_out_finish       dut -> host result signals
// Modport slave is the fc_argmax side, master is the host/BRAM side.
interface fc_argmax_if #(
  parameter int unsigned DW = 16
);

  logic                                  fc_out_en;
  logic                                  fm_bram_1_enb;
  logic [fc_argmax_pkg::FM_ADDR_W-1:0]   fm_bram_1_addrb;
  logic [fc_argmax_pkg::FM_WORD_W-1:0]   fm_bram_1_doutb;
  logic                                  fm_bram_1_rdb_vld;
  logic [fc_argmax_pkg::CLASS_ID_W-1:0]  class_id;
  logic [DW-1:0]                         class_score;
  logic [fc_argmax_pkg::CLASS_ID_W-1:0]  second_id;
  logic [DW:0]                           margin;
  logic                                  result_vld;
  logic                                  fc_out_finish;

  modport slave (
    input  fc_out_en,
    input  fm_bram_1_doutb,
    input  fm_bram_1_rdb_vld,
    output fm_bram_1_enb,
    output fm_bram_1_addrb,
    output class_id,
    output class_score,
    output second_id,
    output margin,
    output result_vld,
    output fc_out_finish
  );

  modport master (
    output fc_out_en,
    output fm_bram_1_doutb,
    output fm_bram_1_rdb_vld,
    input  fm_bram_1_enb,
    input  fm_bram_1_addrb,
    input  class_id,
    input  class_score,
    input  second_id,
    input  margin,
    input  result_vld,
    input  fc_out_finish
  );

endinterface

// File: rtl/fc_argmax_top2_tracker.sv
// Running best / runner-up tracker for a serial scan of signed scores.
//   clk, rst       clock, async active-low reset
//   lane_i         score of the lane being scanned
//   idx_i          index of that lane
//   load_i         first lane: seed best, runner-up set to most-negative value
//   step_i         later lanes: strict-greater update, so ties keep the lower index
//   best_o/_id_o   current maximum and its index
//   second_o/_id_o current runner-up and its index
module fc_argmax_top2_tracker
  import fc_argmax_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         lane_i,
  input  logic [CLASS_ID_W-1:0] idx_i,
  input  logic                  load_i,
  input  logic                  step_i,
  output logic [DW-1:0]         best_o,
  output logic [CLASS_ID_W-1:0] best_id_o,
  output logic [DW-1:0]         second_o,
  output logic [CLASS_ID_W-1:0] second_id_o
);

  localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]         best_q;
  logic [CLASS_ID_W-1:0] best_id_q;
  logic [DW-1:0]         second_q;
  logic [CLASS_ID_W-1:0] second_id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q      <= '0;
      best_id_q   <= '0;
      second_q    <= '0;
      second_id_q <= '0;
    end else if (load_i) begin
      best_q      <= lane_i;
      best_id_q   <= '0;
      second_q    <= MinVal;
      second_id_q <= '0;
    end else if (step_i) begin
      if ($signed(lane_i) > $signed(best_q)) begin
        // New maximum: old best is demoted to runner-up
        second_q    <= best_q;
        second_id_q <= best_id_q;
        best_q      <= lane_i;
        best_id_q   <= idx_i;
      end else if ($signed(lane_i) > $signed(second_q)) begin
        second_q    <= lane_i;
        second_id_q <= idx_i;
      end
    end
  end

  assign best_o      = best_q;
  assign best_id_o   = best_id_q;
  assign second_o    = second_q;
  assign second_id_o = second_id_q;

endmodule

// File: rtl/fc_argmax.sv
// Classifier output stage: reads the final score word from fm_bram_1 once, scans
// NUM_CLASS lanes one per cycle and commits winner, runner-up and margin.
//   clk   clock
//   rst   async reset, active-low
//   bus   fc_argmax_if slave: start/enable, BRAM read port, result outputs
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASS = NUM_CLASS_DEF,
  parameter int unsigned DW        = FM_LANE_W,
  parameter int unsigned RES_ADDR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  fc_argmax_if.slave   bus
);

  localparam int unsigned           VecW    = NUM_CLASS * FM_LANE_W;
  localparam logic [CLASS_ID_W-1:0] LastIdx = CLASS_ID_W'(NUM_CLASS - 1);
  localparam logic [FM_ADDR_W-1:0]  ResAddr = FM_ADDR_W'(RES_ADDR);

  state_e                state_q;
  logic                  en_q;
  logic                  start;
  logic                  enb_q;
  logic [FM_ADDR_W-1:0]  addr_q;
  logic [VecW-1:0]       score_vec_q;
  logic [CLASS_ID_W-1:0] idx_q;
  logic [CLASS_ID_W-1:0] class_id_q;
  logic [DW-1:0]         class_score_q;
  logic [CLASS_ID_W-1:0] second_id_q;
  logic [DW:0]           margin_q;
  logic                  result_vld_q;
  logic                  finish_q;

  logic [DW-1:0]         lane;
  logic                  trk_load;
  logic                  trk_step;
  logic [DW-1:0]         best;
  logic [CLASS_ID_W-1:0] best_id;
  logic [DW-1:0]         second;
  logic [CLASS_ID_W-1:0] second_id;
  logic [DW:0]           margin_d;

  // Lanes at and above NUM_CLASS carry no scores for this stage
  logic unused_hi_lanes;
  assign unused_hi_lanes = ^bus.fm_bram_1_doutb[FM_WORD_W-1:VecW];

  assign start = bus.fc_out_en & ~en_q;

  always_comb begin
    lane = '0;
    for (int k = 0; k < int'(NUM_CLASS); k++) begin
      if (idx_q == CLASS_ID_W'(k)) lane = score_vec_q[k*FM_LANE_W +: DW];
    end
  end

  assign trk_load = (state_q == StScan) && (idx_q == '0);
  assign trk_step = (state_q == StScan) && (idx_q != '0);

  // Sign-extend both operands so the difference fits without wrap
  assign margin_d = {best[DW-1], best} - {second[DW-1], second};

  fc_argmax_top2_tracker #(
    .DW (DW)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .lane_i      (lane),
    .idx_i       (idx_q),
    .load_i      (trk_load),
    .step_i      (trk_step),
    .best_o      (best),
    .best_id_o   (best_id),
    .second_o    (second),
    .second_id_o (second_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      en_q          <= 1'b0;
      enb_q         <= 1'b0;
      addr_q        <= '0;
      score_vec_q   <= '0;
      idx_q         <= '0;
      class_id_q    <= '0;
      class_score_q <= '0;
      second_id_q   <= '0;
      margin_q      <= '0;
      result_vld_q  <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      en_q   <= bus.fc_out_en;
      enb_q  <= 1'b0;
      addr_q <= ResAddr;
      if (!bus.fc_out_en) begin
        // Abort: partial scan dropped, committed results kept
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q      <= StRd;
              enb_q        <= 1'b1;
              finish_q     <= 1'b0;
              result_vld_q <= 1'b0;
            end
          end
          StRd: begin
            state_q <= StWait;
          end
          StWait: begin
            if (bus.fm_bram_1_rdb_vld) begin
              score_vec_q <= bus.fm_bram_1_doutb[VecW-1:0];
              idx_q       <= '0;
              state_q     <= StScan;
            end
          end
          StScan: begin
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StDone: begin
            class_id_q    <= best_id;
            class_score_q <= best;
            second_id_q   <= second_id;
            margin_q      <= margin_d;
            result_vld_q  <= 1'b1;
            finish_q      <= 1'b1;
            state_q       <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.fm_bram_1_enb   = enb_q;
  assign bus.fm_bram_1_addrb = addr_q;
  assign bus.class_id        = class_id_q;
  assign bus.class_score     = class_score_q;
  assign bus.second_id       = second_id_q;
  assign bus.margin          = margin_q;
  assign bus.result_vld      = result_vld_q;
  assign bus.fc_out_finish   = finish_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax with a small BRAM model of configurable latency.
module tb_fc_argmax;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   lat;
  int   enb_cnt;
  logic [6:0] addr_seen;
  logic model_vld;
  logic man_vld;
  logic [895:0] bram_word;
  logic [15:0] lanes [10];

  fc_argmax_if #(.DW(16)) bus ();

  fc_argmax #(
    .NUM_CLASS (10),
    .DW        (16),
    .RES_ADDR  (0)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  assign bus.fm_bram_1_doutb   = bram_word;
  assign bus.fm_bram_1_rdb_vld = model_vld | man_vld;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.fm_bram_1_enb === 1'b1) enb_cnt <= enb_cnt + 1;
  end

  // BRAM model: strobe valid L cycles after the enable cycle
  initial begin
    model_vld = 1'b0;
    addr_seen = '0;
    forever begin
      @(posedge clk);
      if (bus.fm_bram_1_enb === 1'b1) begin
        addr_seen = bus.fm_bram_1_addrb;
        repeat (lat - 1) @(posedge clk);
        #1 model_vld = 1'b1;
        @(posedge clk);
        #1 model_vld = 1'b0;
      end
    end
  end

  task automatic load_word();
    for (int i = 0; i < 56; i++) begin
      bram_word[i*16 +: 16] = (i < 10) ? lanes[i] : 16'h7FFF;
    end
  endtask

  task automatic drop_en();
    @(posedge clk);
    #1 bus.fc_out_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Raise en and count edges until finish is seen (bounded)
  task automatic run_start(output int n);
    @(posedge clk);
    #1 bus.fc_out_en = 1'b1;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.fc_out_finish === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fc_out_en = 1'b0;
    man_vld = 1'b0;
    lat = 2;
    enb_cnt = 0;
    bram_word = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id, bus.margin} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_results got %h want 0",
               {bus.class_id, bus.class_score, bus.second_id, bus.margin});
    end
    vectors++;
    if ({bus.result_vld, bus.fc_out_finish, bus.fm_bram_1_enb} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000",
               {bus.result_vld, bus.fc_out_finish, bus.fm_bram_1_enb});
    end
  endtask

  task automatic test_basic_max();
    int n;
    int e0;
    lanes = '{16'd5, 16'hFFFD, 16'd100, 16'd7, 16'd99, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    load_word();
    lat = 2;
    e0 = enb_cnt;
    run_start(n);
    vectors++;
    if (n !== 15) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 15", n);
    end
    vectors++;
    if ({bus.class_id, bus.class_score} !== {4'd2, 16'd100}) begin
      miscompares++;
      $display("FAIL basic_class got id=%0d score=%h want id=2 score=0064",
               bus.class_id, bus.class_score);
    end
    vectors++;
    if ({bus.second_id, bus.margin} !== {4'd4, 17'd1}) begin
      miscompares++;
      $display("FAIL basic_second got id=%0d margin=%h want id=4 margin=1",
               bus.second_id, bus.margin);
    end
    vectors++;
    if (bus.result_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_vld got %b want 1", bus.result_vld);
    end
    vectors++;
    if ((enb_cnt - e0) !== 1 || addr_seen !== 7'd0) begin
      miscompares++;
      $display("FAIL basic_read got enb_cycles=%0d addr=%0d want 1 and 0",
               enb_cnt - e0, addr_seen);
    end
    drop_en();
  endtask

  task automatic test_ties();
    int n;
    lanes = '{default: 16'h0000};
    load_word();
    run_start(n);
    vectors++;
    if ({bus.class_id, bus.second_id, bus.margin} !== {4'd0, 4'd1, 17'd0}) begin
      miscompares++;
      $display("FAIL ties got id=%0d second=%0d margin=%h want 0 1 0",
               bus.class_id, bus.second_id, bus.margin);
    end
    drop_en();
  endtask

  task automatic test_negative();
    int n;
    lanes = '{default: 16'h8000};
    lanes[7] = 16'h8001;
    load_word();
    run_start(n);
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id, bus.margin}
        !== {4'd7, 16'h8001, 4'd0, 17'd1}) begin
      miscompares++;
      $display("FAIL negative got id=%0d score=%h second=%0d margin=%h want 7 8001 0 1",
               bus.class_id, bus.class_score, bus.second_id, bus.margin);
    end
    drop_en();
  endtask

  task automatic test_wide_margin();
    int n;
    lanes = '{default: 16'h8000};
    lanes[3] = 16'h7FFF;
    load_word();
    run_start(n);
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id} !== {4'd3, 16'h7FFF, 4'd0}) begin
      miscompares++;
      $display("FAIL wide_class got id=%0d score=%h second=%0d want 3 7fff 0",
               bus.class_id, bus.class_score, bus.second_id);
    end
    vectors++;
    if (bus.margin !== 17'h0FFFF) begin
      miscompares++;
      $display("FAIL wide_margin got %h want 0ffff", bus.margin);
    end
    drop_en();
  endtask

  task automatic test_abort_restart();
    int n;
    lanes = '{default: 16'd0};
    lanes[9] = 16'd50;
    load_word();
    @(posedge clk);
    #1 bus.fc_out_en = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.fc_out_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.fc_out_finish, bus.result_vld} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_flags got %b want 00", {bus.fc_out_finish, bus.result_vld});
    end
    vectors++;
    if ({bus.class_id, bus.class_score, bus.margin} !== {4'd3, 16'h7FFF, 17'h0FFFF}) begin
      miscompares++;
      $display("FAIL abort_held got id=%0d score=%h margin=%h want 3 7fff 0ffff",
               bus.class_id, bus.class_score, bus.margin);
    end
    lanes = '{16'hFFFF, 16'd2, 16'd2, 16'hFFFB, 16'd0, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0};
    load_word();
    @(posedge clk);
    #1 man_vld = 1'b1;
    @(posedge clk);
    #1 man_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.class_id, bus.second_id, bus.fc_out_finish, bus.fm_bram_1_enb}
        !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL spurious_vld got id=%0d second=%0d fin=%b enb=%b want 3 0 0 0",
               bus.class_id, bus.second_id, bus.fc_out_finish, bus.fm_bram_1_enb);
    end
    run_start(n);
    vectors++;
    if (n !== 15) begin
      miscompares++;
      $display("FAIL restart_latency got %0d want 15", n);
    end
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id, bus.margin}
        !== {4'd1, 16'd2, 4'd2, 17'd0}) begin
      miscompares++;
      $display("FAIL restart_result got id=%0d score=%h second=%0d margin=%h want 1 0002 2 0",
               bus.class_id, bus.class_score, bus.second_id, bus.margin);
    end
    drop_en();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    lanes = '{16'd5, 16'hFFFD, 16'd100, 16'd7, 16'd99, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    load_word();
    lat = 5;
    @(posedge clk);
    #1 bus.fc_out_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id, bus.margin,
         bus.result_vld, bus.fc_out_finish, bus.fm_bram_1_enb} !== 44'd0) begin
      miscompares++;
      $display("FAIL rst_mid_wait got id=%0d score=%h second=%0d margin=%h vld=%b fin=%b",
               bus.class_id, bus.class_score, bus.second_id, bus.margin,
               bus.result_vld, bus.fc_out_finish);
    end
    bus.fc_out_en = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_start(n);
    vectors++;
    if (n !== 18) begin
      miscompares++;
      $display("FAIL slow_bram_latency got %0d want 18", n);
    end
    vectors++;
    if ({bus.class_id, bus.class_score, bus.second_id, bus.margin}
        !== {4'd2, 16'd100, 4'd4, 17'd1}) begin
      miscompares++;
      $display("FAIL slow_bram_result got id=%0d score=%h second=%0d margin=%h want 2 0064 4 1",
               bus.class_id, bus.class_score, bus.second_id, bus.margin);
    end
    drop_en();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_max();
    test_ties();
    test_negative();
    test_wide_margin();
    test_abort_restart();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
